// File: rtl/snake_game_sequencer.sv
// snake_game_sequencer
//   Game-flow controller for the snake game. It generates the movement tick
//   and sequences each step through the movement and food-placement blocks
//   using req/ack handshakes. It also keeps the 4-digit BCD score and speeds
//   up the step period as food is eaten.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   start       raw start/restart button level (asynchronous to clk)
//   pause       while high, the tick counter holds its value
//   move_req    request one snake step       / move_ack  step done
//   collision   from the snake block, sampled while move_ack is high
//   food_eaten  from the snake block, sampled while move_ack is high
//   grow        one-cycle pulse: lengthen the snake
//   food_req    request a new food position  / food_ack  food placed
//   game_clear  one-cycle pulse: reinitialise the snake and food blocks
//   score       4-digit BCD score, digit 3 in [15:12]
//   game_over   high in the OVER state
//   state       current FSM state (debug)
module snake_game_sequencer #(
  parameter int unsigned TICK_DIV      = 12500000,
  parameter int unsigned TICK_STEP     = 1000000,
  parameter int unsigned TICK_MIN      = 4000000,
  parameter int unsigned SPEEDUP_EVERY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  output logic        move_req,
  input  logic        move_ack,
  input  logic        collision,
  input  logic        food_eaten,
  output logic        grow,
  output logic        food_req,
  input  logic        food_ack,
  output logic        game_clear,
  output logic [15:0] score,
  output logic        game_over,
  output logic [2:0]  state
);

  localparam int unsigned    CW        = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0]  DIV_P     = CW'(TICK_DIV);
  localparam logic [CW-1:0]  MIN_P     = CW'(TICK_MIN);
  localparam logic [3:0]     SPEEDUP_P = 4'(SPEEDUP_EVERY);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    MOVE      = 3'd2,
    CHECK     = 3'd3,
    FOOD      = 3'd4,
    OVER      = 3'd5
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic          s1;
  logic          s2;
  logic          s3;
  logic          start_edge;

  logic [CW-1:0] tick_cnt;
  logic [CW-1:0] period;
  logic [CW-1:0] period_next;
  logic [31:0]   period_w;
  logic          tick_done;
  logic [3:0]    food_cnt;
  logic          col_l;
  logic          food_l;
  logic          game_clear_q;
  logic [15:0]   score_q;
  logic          restart;

  // BCD increment with per-digit wrap; 9999 saturates.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      return v;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Start button: 2-flop synchroniser plus one history flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= start;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign start_edge = s2 & ~s3;
  assign restart    = start_edge & ((state_q == IDLE) || (state_q == OVER));
  assign tick_done  = (state_q == WAIT_TICK) && !pause && (tick_cnt == period - CW'(1));

  // Comparisons run at 32 bits so the floor check happens before any
  // subtraction and cannot wrap.
  assign period_w = 32'(period);
  always_comb begin
    if ((period_w > TICK_MIN) && ((period_w - TICK_MIN) > TICK_STEP)) begin
      period_next = CW'(period_w - TICK_STEP);
    end else begin
      period_next = MIN_P;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: if (start_edge) state_d = FOOD;
      WAIT_TICK:  if (tick_done)  state_d = MOVE;
      MOVE:       if (move_ack)   state_d = CHECK;
      CHECK: begin
        if (col_l) begin
          state_d = OVER;
        end else if (food_l) begin
          state_d = FOOD;
        end else begin
          state_d = WAIT_TICK;
        end
      end
      FOOD:       if (food_ack)   state_d = WAIT_TICK;
      default:    state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    move_req  = 1'b0;
    food_req  = 1'b0;
    game_over = 1'b0;
    grow      = 1'b0;
    case (state_q)
      MOVE:    move_req  = 1'b1;
      FOOD:    food_req  = 1'b1;
      OVER:    game_over = 1'b1;
      CHECK:   grow      = food_l & ~col_l;
      default: ;
    endcase
  end

  assign game_clear = game_clear_q;
  assign score      = score_q;
  assign state      = state_q;

  // Datapath: tick counter, period, food count, latched flags, score.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt     <= '0;
      period       <= DIV_P;
      food_cnt     <= '0;
      col_l        <= 1'b0;
      food_l       <= 1'b0;
      game_clear_q <= 1'b0;
      score_q      <= '0;
    end else begin
      game_clear_q <= restart;
      if (restart) begin
        tick_cnt <= '0;
        period   <= DIV_P;
        food_cnt <= '0;
        col_l    <= 1'b0;
        food_l   <= 1'b0;
        score_q  <= '0;
      end
      if ((state_q == WAIT_TICK) && !pause) begin
        tick_cnt <= tick_done ? '0 : tick_cnt + CW'(1);
      end
      if ((state_q == MOVE) && move_ack) begin
        col_l  <= collision;
        food_l <= food_eaten;
      end
      if (grow) begin
        score_q <= bcd_inc(score_q);
        if (food_cnt + 4'd1 >= SPEEDUP_P) begin
          food_cnt <= '0;
          period   <= period_next;
        end else begin
          food_cnt <= food_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_game_sequencer.sv
// tb_snake_game_sequencer
//   Directed bench for snake_game_sequencer. Three instances with different
//   tick parameters share the stimulus inputs; only the selected one is out
//   of reset at a time. Score results are predicted from a decimal model and
//   queued when a food-eaten step is driven, then popped when the DUT
//   updates its score.
module tb_snake_game_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v;
  logic        start;
  logic        pause;
  logic        move_ack;
  logic        collision;
  logic        food_eaten;
  logic        food_ack;
  logic [2:0]  move_req_v;
  logic [2:0]  grow_v;
  logic [2:0]  food_req_v;
  logic [2:0]  game_clear_v;
  logic [2:0]  game_over_v;
  logic [15:0] score_v [3];
  logic [2:0]  state_v [3];

  int unsigned sel;
  int          checks = 0;
  int          errors = 0;
  int          model_score;
  logic [15:0] exp_q [$];

  // 0: div 8 / step 2 / min 4 / every 4
  // 1: div 20 / step 6 / min 10 / every 1
  // 2: div 1 / step 1 / min 1 / every 15 (fast stepping for score runs)
  for (genvar g = 0; g < 3; g++) begin : g_dut
    snake_game_sequencer #(
      .TICK_DIV     (g == 0 ? 8 : (g == 1 ? 20 : 1)),
      .TICK_STEP    (g == 0 ? 2 : (g == 1 ? 6  : 1)),
      .TICK_MIN     (g == 0 ? 4 : (g == 1 ? 10 : 1)),
      .SPEEDUP_EVERY(g == 0 ? 4 : (g == 1 ? 1  : 15))
    ) u_dut (
      .clk       (clk),
      .reset     (rst_v[g]),
      .start     (start),
      .pause     (pause),
      .move_req  (move_req_v[g]),
      .move_ack  (move_ack),
      .collision (collision),
      .food_eaten(food_eaten),
      .grow      (grow_v[g]),
      .food_req  (food_req_v[g]),
      .food_ack  (food_ack),
      .game_clear(game_clear_v[g]),
      .score     (score_v[g]),
      .game_over (game_over_v[g]),
      .state     (state_v[g])
    );
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Starts at the negedge where WAIT_TICK was just entered; counts cycles
  // until move_req rises, holding pause for p_len cycles from cycle p_at.
  task automatic measure(input int exp_n, input int p_at, input int p_len, input string tag);
    int n = 0;
    check({tag, "_entry"}, 32'(state_v[sel]), 32'd1);
    while (move_req_v[sel] !== 1'b1 && n < 200) begin
      pause = (n >= p_at) && (n < p_at + p_len);
      tick();
      n++;
    end
    pause = 1'b0;
    check(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic do_move(input logic col, input logic food, input int delay, input string tag);
    logic        exp_grow;
    logic [15:0] exp_score;
    logic [2:0]  exp_state;
    check({tag, "_req"}, 32'(move_req_v[sel]), 32'd1);
    for (int i = 0; i < delay; i++) begin
      tick();
      check({tag, "_req_hold"}, 32'(move_req_v[sel]), 32'd1);
    end
    move_ack   = 1'b1;
    collision  = col;
    food_eaten = food;
    tick();
    move_ack   = 1'b0;
    collision  = 1'b0;
    food_eaten = 1'b0;
    check({tag, "_in_check"}, 32'(state_v[sel]), 32'd3);
    check({tag, "_req_drop"}, 32'(move_req_v[sel]), 32'd0);
    exp_grow = food & ~col;
    check({tag, "_grow"}, 32'(grow_v[sel]), 32'(exp_grow));
    if (exp_grow) begin
      model_score = (model_score < 9999) ? model_score + 1 : 9999;
      exp_q.push_back(to_bcd(model_score));
    end
    tick();
    if (exp_q.size() > 0) exp_score = exp_q.pop_front();
    else                  exp_score = to_bcd(model_score);
    check({tag, "_score"}, 32'(score_v[sel]), 32'(exp_score));
    check({tag, "_grow_end"}, 32'(grow_v[sel]), 32'd0);
    exp_state = col ? 3'd5 : (food ? 3'd4 : 3'd1);
    check({tag, "_next"}, 32'(state_v[sel]), 32'(exp_state));
    if (col) check({tag, "_game_over"}, 32'(game_over_v[sel]), 32'd1);
  endtask

  task automatic do_food(input int delay, input string tag);
    check({tag, "_req"}, 32'(food_req_v[sel]), 32'd1);
    for (int i = 0; i < delay; i++) begin
      tick();
      check({tag, "_req_hold"}, 32'(food_req_v[sel]), 32'd1);
    end
    food_ack = 1'b1;
    tick();
    food_ack = 1'b0;
    check({tag, "_wait"}, 32'(state_v[sel]), 32'd1);
    check({tag, "_req_drop"}, 32'(food_req_v[sel]), 32'd0);
  endtask

  // Leaves start high; returns at the negedge after the FOOD entry edge.
  task automatic start_game(input logic [2:0] prev, input string tag);
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check({tag, "_hold_state"}, 32'(state_v[sel]), 32'(prev));
      check({tag, "_no_clear"}, 32'(game_clear_v[sel]), 32'd0);
    end
    tick();
    check({tag, "_food"}, 32'(state_v[sel]), 32'd4);
    check({tag, "_clear"}, 32'(game_clear_v[sel]), 32'd1);
    check({tag, "_score0"}, 32'(score_v[sel]), 32'd0);
    check({tag, "_food_req"}, 32'(food_req_v[sel]), 32'd1);
    check({tag, "_not_over"}, 32'(game_over_v[sel]), 32'd0);
    model_score = 0;
    exp_q.delete();
  endtask

  initial begin
    rst_v       = '0;
    start       = 1'b0;
    pause       = 1'b0;
    move_ack    = 1'b0;
    collision   = 1'b0;
    food_eaten  = 1'b0;
    food_ack    = 1'b0;
    sel         = 0;
    model_score = 0;

    // Reset state
    tick();
    tick();
    check("rst_state", 32'(state_v[0]), 32'd0);
    check("rst_score", 32'(score_v[0]), 32'd0);
    check("rst_move_req", 32'(move_req_v[0]), 32'd0);
    check("rst_food_req", 32'(food_req_v[0]), 32'd0);
    check("rst_grow", 32'(grow_v[0]), 32'd0);
    check("rst_clear", 32'(game_clear_v[0]), 32'd0);
    check("rst_over", 32'(game_over_v[0]), 32'd0);
    rst_v[0] = 1'b1;
    tick();
    tick();
    check("idle_after_rst", 32'(state_v[0]), 32'd0);

    // Start: clear pulse on third edge, food placed after two cycles
    start_game(3'd0, "t1");
    tick();
    check("t1_clear_once", 32'(game_clear_v[0]), 32'd0);
    check("t1_food_req", 32'(food_req_v[0]), 32'd1);
    food_ack = 1'b1;
    tick();
    food_ack = 1'b0;
    start    = 1'b0;
    check("t1_wait", 32'(state_v[0]), 32'd1);
    check("t1_score", 32'(score_v[0]), 32'd0);
    check("t1_food_drop", 32'(food_req_v[0]), 32'd0);

    // Step interval, plain and with pause
    measure(8, 1000, 0, "t2_interval");
    do_move(1'b0, 1'b0, 0, "t2_move");
    measure(13, 2, 5, "t2_pause");

    // Eat: grow, score 0001, food request
    do_move(1'b0, 1'b1, 2, "t3_eat");
    do_food(1, "t3_food");
    measure(8, 1000, 0, "t3_interval");

    // Collision with food: OVER, no grow, score held; ignored acks
    do_move(1'b1, 1'b1, 0, "t4_col");
    move_ack = 1'b1;
    food_ack = 1'b1;
    repeat (3) tick();
    move_ack = 1'b0;
    food_ack = 1'b0;
    check("t4_over_hold", 32'(state_v[0]), 32'd5);
    check("t4_over_flag", 32'(game_over_v[0]), 32'd1);
    check("t4_score_held", 32'(score_v[0]), 32'h0001);
    check("t4_no_move_req", 32'(move_req_v[0]), 32'd0);
    start_game(3'd5, "t4_restart");
    start = 1'b0;
    do_food(0, "t4_food");
    measure(8, 1000, 0, "t4_interval");

    // Reset during a move handshake
    check("t6_move_req", 32'(move_req_v[0]), 32'd1);
    #2 rst_v[0] = 1'b0;
    #1;
    check("t6_req_async_drop", 32'(move_req_v[0]), 32'd0);
    check("t6_state_idle", 32'(state_v[0]), 32'd0);
    @(negedge clk);
    rst_v[0] = 1'b1;
    move_ack = 1'b1;
    tick();
    tick();
    move_ack = 1'b0;
    check("t6_late_ack_state", 32'(state_v[0]), 32'd0);
    check("t6_late_ack_req", 32'(move_req_v[0]), 32'd0);
    rst_v[0] = 1'b0;

    // Speed-up: 20, 14, 10, 10
    sel      = 1;
    rst_v[1] = 1'b1;
    tick();
    start_game(3'd0, "t5_start");
    start = 1'b0;
    do_food(0, "t5_food0");
    measure(20, 1000, 0, "t5_p20");
    do_move(1'b0, 1'b1, 0, "t5_eat1");
    do_food(0, "t5_food1");
    measure(14, 1000, 0, "t5_p14");
    do_move(1'b0, 1'b1, 0, "t5_eat2");
    do_food(0, "t5_food2");
    measure(10, 1000, 0, "t5_p10a");
    do_move(1'b0, 1'b1, 0, "t5_eat3");
    do_food(0, "t5_food3");
    measure(10, 1000, 0, "t5_p10b");
    rst_v[1] = 1'b0;

    // BCD carries through 0010, 0100, 1000 and saturation at 9999
    sel      = 2;
    rst_v[2] = 1'b1;
    tick();
    start_game(3'd0, "t3_fast_start");
    start = 1'b0;
    do_food(0, "t3_fast_food0");
    for (int i = 0; i < 10001; i++) begin
      measure(1, 1000, 0, "t3_fast_tick");
      do_move(1'b0, 1'b1, 0, "t3_fast_eat");
      do_food(0, "t3_fast_food");
    end
    check("t3_saturated", 32'(score_v[2]), 32'h9999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
